if_id_fifo: RTL and testbench

Parametrised successor of the single-register IF/ID latch. It decouples fetch from decode with a DEPTH-entry instruction/PC queue plus a registered decode-side output stage. Fetch can keep delivering while decode is stalled, and a flush from branch or exception logic empties the queue in one cycle. When nothing is available, the block presents a zero bubble to ID, exactly as the old latch did on a stall.

---
 rtl/if_id_fifo.sv | 96 +++++++++
 tb/tb_if_id_fifo.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/if_id_fifo.sv
// IF/ID decoupling queue: DEPTH-entry instruction/PC buffer feeding a
// registered decode-side output stage with empty-queue bypass and flush.
module if_id_fifo #(
  parameter int INST_W = 32,
  parameter int PC_W   = 32,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = $clog2(DEPTH+1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_valid,
  input  logic [INST_W-1:0] if_inst,
  input  logic [PC_W-1:0]   if_pc,
  output logic              if_ready,
  input  logic              id_stall,
  input  logic              flush,
  output logic [INST_W-1:0] id_inst,
  output logic [PC_W-1:0]   id_pc,
  output logic              id_valid,
  output logic [CNT_W-1:0]  count,
  output logic              ovf_err
);

  localparam int AW = $clog2(DEPTH);

  logic [INST_W+PC_W-1:0] mem [DEPTH];
  logic [AW-1:0]          wr_ptr;
  logic [AW-1:0]          rd_ptr;
  logic [INST_W-1:0]      head_inst;
  logic [PC_W-1:0]        head_pc;
  logic                   empty;
  logic                   push;
  logic                   pop;
  logic                   wr_en;

  // ready looks only at occupancy, so a full queue refuses even on a pop
  assign if_ready = count < CNT_W'(DEPTH);
  assign empty    = count == '0;
  assign push     = if_valid && if_ready;
  assign pop      = !id_stall && !empty;
  assign wr_en    = push && !rst && !flush
                  && (id_stall || !empty);

  assign {head_inst, head_pc} = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= {if_inst, if_pc};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      id_inst  <= '0;
      id_pc    <= '0;
      id_valid <= 1'b0;
      ovf_err  <= 1'b0;
    end else if (flush) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      id_inst  <= '0;
      id_pc    <= '0;
      id_valid <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      if (wr_en && !pop)
        count <= count + 1'b1;
      else if (pop && !wr_en)
        count <= count - 1'b1;
      if (if_valid && !if_ready)
        ovf_err <= 1'b1;
      priority case (1'b1)
        id_stall: ;
        !empty: begin
          id_inst  <= head_inst;
          id_pc    <= head_pc;
          id_valid <= 1'b1;
        end
        if_valid: begin
          id_inst  <= if_inst;
          id_pc    <= if_pc;
          id_valid <= 1'b1;
        end
        default: begin
          id_inst  <= '0;
          id_pc    <= '0;
          id_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_if_id_fifo.sv
// Bench for if_id_fifo: queue-level reference model compared every
// cycle, plus directed literal checks and a random stall/flush phase.
module tb_if_id_fifo;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_valid;
  logic [31:0] if_inst;
  logic [31:0] if_pc;
  logic        if_ready;
  logic        id_stall;
  logic        flush;
  logic [31:0] id_inst;
  logic [31:0] id_pc;
  logic        id_valid;
  logic [2:0]  count;
  logic        ovf_err;

  int n_vec = 0;
  int n_mis = 0;
  bit chk_en = 0;

  logic [63:0] q[$];
  logic [31:0] e_inst;
  logic [31:0] e_pc;
  logic        e_valid;
  logic        e_ovf;

  if_id_fifo #(.INST_W(32), .PC_W(32), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .if_valid(if_valid), .if_inst(if_inst), .if_pc(if_pc),
    .if_ready(if_ready), .id_stall(id_stall), .flush(flush),
    .id_inst(id_inst), .id_pc(id_pc), .id_valid(id_valid),
    .count(count), .ovf_err(ovf_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               nm, act, exp, $time);
    end
  endtask

  // reference model: a queue of accepted words plus the presented word
  always @(posedge clk) begin
    automatic bit rdy = q.size() < DEPTH;
    automatic logic [63:0] w;
    if (rst) begin
      q.delete();
      e_inst = 0; e_pc = 0; e_valid = 0; e_ovf = 0;
    end else if (flush) begin
      q.delete();
      e_inst = 0; e_pc = 0; e_valid = 0;
    end else begin
      if (if_valid && !rdy) e_ovf = 1;
      if (!id_stall) begin
        if (q.size() > 0) begin
          w = q.pop_front();
          {e_inst, e_pc} = w;
          e_valid = 1;
          if (if_valid && rdy) q.push_back({if_inst, if_pc});
        end else if (if_valid) begin
          e_inst = if_inst; e_pc = if_pc; e_valid = 1;
        end else begin
          e_inst = 0; e_pc = 0; e_valid = 0;
        end
      end else if (if_valid && rdy) begin
        q.push_back({if_inst, if_pc});
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("id_valid", 64'(id_valid), 64'(e_valid));
      chk("id_inst", 64'(id_inst), 64'(e_inst));
      chk("id_pc", 64'(id_pc), 64'(e_pc));
      chk("count", 64'(count), 64'(q.size()));
      chk("if_ready", 64'(if_ready), 64'(q.size() < DEPTH));
      chk("ovf_err", 64'(ovf_err), 64'(e_ovf));
    end
  end

  task automatic drive(input logic v, input logic [31:0] pc,
                       input logic st, input logic fl);
    if_valid = v;
    if_pc    = pc;
    if_inst  = pc ^ 32'hC0DE_0000;
    id_stall = st;
    flush    = fl;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1; if_valid = 0; if_inst = 0; if_pc = 0;
    id_stall = 0; flush = 0;
    @(posedge clk); #1;
    chk_en = 1;
    @(posedge clk); #1;
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_valid", 64'(id_valid), 64'd0);
    chk("rst_ready", 64'(if_ready), 64'd1);
    chk("rst_ovf", 64'(ovf_err), 64'd0);
    rst = 0;

    drive(1, 32'h00, 0, 0);
    chk("s0_pc", 64'(id_pc), 64'h00);
    chk("s0_valid", 64'(id_valid), 64'd1);
    drive(1, 32'h04, 0, 0);
    chk("s1_pc", 64'(id_pc), 64'h04);
    drive(1, 32'h08, 0, 0);
    chk("s2_pc", 64'(id_pc), 64'h08);
    chk("s2_inst", 64'(id_inst), 64'hC0DE_0008);
    chk("s2_count", 64'(count), 64'd0);

    drive(0, 32'h0, 0, 0);
    drive(1, 32'h00, 0, 0);
    for (int i = 1; i <= 4; i++) begin
      drive(1, 32'(4 * i), 1, 0);
      chk("fill_count", 64'(count), 64'(i));
      chk("fill_hold", 64'(id_pc), 64'h00);
    end
    chk("full_ready", 64'(if_ready), 64'd0);
    drive(1, 32'h14, 1, 0);
    chk("ovf_set", 64'(ovf_err), 64'd1);
    chk("ovf_count", 64'(count), 64'd4);

    for (int i = 0; i < 4; i++) begin
      drive(1, 32'(32'h14 + 4 * i), 0, 0);
      chk("drain_pc", 64'(id_pc), 64'(4 + 4 * i));
      chk("drain_count", 64'(count), 64'd3);
    end
    chk("ovf_sticky", 64'(ovf_err), 64'd1);

    drive(1, 32'h40, 0, 1);
    chk("fl_count", 64'(count), 64'd0);
    chk("fl_valid", 64'(id_valid), 64'd0);
    chk("fl_pc", 64'(id_pc), 64'd0);
    chk("fl_inst", 64'(id_inst), 64'd0);
    drive(1, 32'h80, 0, 0);
    chk("post_fl_pc", 64'(id_pc), 64'h80);
    for (int i = 0; i < 2; i++) begin
      drive(0, 32'h0, 0, 0);
      chk("bub_valid", 64'(id_valid), 64'd0);
      chk("bub_pc", 64'(id_pc), 64'd0);
      chk("bub_inst", 64'(id_inst), 64'd0);
    end

    rst = 1;
    drive(0, 32'h0, 0, 0);
    rst = 0;
    chk("rst2_ovf", 64'(ovf_err), 64'd0);

    // wrap run without overflow: only offer words when room exists
    for (int i = 0; i < 60; i++) begin
      automatic bit v = ($urandom_range(0, 9) < 7) && (q.size() < DEPTH);
      drive(v, $urandom, $urandom_range(0, 9) < 5, 0);
    end
    chk("wrap_no_ovf", 64'(ovf_err), 64'd0);

    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 9) < 6, $urandom,
            $urandom_range(0, 9) < 4, $urandom_range(0, 99) < 3);
    end
    drive(0, 32'h0, 0, 0);
    drive(0, 32'h0, 0, 0);
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
